test_power_scheduler: RTL and testbench

TEST_POWER_SCHEDULER -- requirements
Module: test_power_scheduler

---
 rtl/test_power_scheduler_pkg.sv | 52 +++++
 rtl/test_power_scheduler_if.sv | 28 ++
 rtl/test_power_scheduler_session_timer.sv | 35 +++
 rtl/test_power_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_test_power_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/test_power_scheduler_pkg.sv
// Shared definitions for the two-layer test power scheduler.
//   ID_W / PWR_W  : widths of chip IDs and per-layer power values
//   SUM_W         : width of a two-layer power sum and of the budget
//   CNT_W         : width of the session timeout counter
//   state_e       : scheduler FSM states
//   snapshot_t    : inputs captured once both layers have sorted
//   peak_power()  : worst-case stack power when both layers test together
package test_power_scheduler_pkg;

  localparam int ID_W  = 4;
  localparam int PWR_W = 4;
  localparam int SUM_W = PWR_W + 1;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    WAIT_SORT,
    DECIDE,
    RUN_BOTH,
    RUN_FIRST,
    RUN_SECOND,
    DONE,
    FAULT
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id0;
    logic [ID_W-1:0]  id1;
    logic [PWR_W-1:0] up0;
    logic [PWR_W-1:0] up1;
    logic [PWR_W-1:0] lo0;
    logic [PWR_W-1:0] lo1;
    logic [SUM_W-1:0] budget;
  } snapshot_t;

  // Largest of the three overlap cases. With lower <= upper this is
  // always up0+up1; evaluating all three stays safe if a layer ever
  // reports an idle figure above its peak.
  function automatic logic [SUM_W-1:0] peak_power(
    input logic [PWR_W-1:0] up0,
    input logic [PWR_W-1:0] up1,
    input logic [PWR_W-1:0] lo0,
    input logic [PWR_W-1:0] lo1
  );
    logic [SUM_W-1:0] a, b, c, m;
    a = SUM_W'(up0) + SUM_W'(lo1);
    b = SUM_W'(up1) + SUM_W'(lo0);
    c = SUM_W'(up0) + SUM_W'(up1);
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/test_power_scheduler_if.sv
// Per-layer link between the scheduler and one stacked die.
//   master : scheduler side (drives test_start / test_en)
//   slave  : layer side (drives sort results, test_done, data_in)
interface test_power_scheduler_if;
  import test_power_scheduler_pkg::*;

  logic             sort_finish;
  logic [ID_W-1:0]  chip_id;
  logic [PWR_W-1:0] power_value_upper;
  logic [PWR_W-1:0] power_value_lower;
  logic             test_done;
  logic             data_in;
  logic             test_start;
  logic             test_en;

  modport master (
    input  sort_finish, chip_id, power_value_upper, power_value_lower,
           test_done, data_in,
    output test_start, test_en
  );

  modport slave (
    output sort_finish, chip_id, power_value_upper, power_value_lower,
           test_done, data_in,
    input  test_start, test_en
  );

endinterface

// File: rtl/test_power_scheduler_session_timer.sv
// Clearable timeout counter for one test session.
//   t_clk, rst_n : clock, async active-low reset
//   clear        : high in the entry cycle of a RUN state; count restarts at 0
//   enable       : high while a RUN state is active; low holds count at 0
//   expired      : this cycle's increment reaches TIMEOUT_CYC
module session_timer
  import test_power_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200
) (
  input  logic t_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] base;

  // The entry cycle counts as zero elapsed cycles, so a session that
  // enters RUN at edge E0 is flagged during its TIMEOUT_CYC-th cycle and
  // leaves RUN on edge E(TIMEOUT_CYC).
  assign base    = clear ? '0 : count;
  assign expired = enable && ((base + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));

  // NOTE: state registers use non-blocking assignments so every flop in
  // the design samples its inputs at the same instant of the edge.
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n)       count <= '0;
    else if (!enable) count <= '0;
    else              count <= base + CNT_W'(1);
  end

endmodule

// File: rtl/test_power_scheduler.sv
// Schedules self-test of two stacked layers under a stack power budget.
// Once both layers have sorted, their IDs and powers are captured; if both
// peak powers fit the budget the layers test in parallel, otherwise the
// lower-ID layer tests first and the other follows.
//   t_clk, rst_n     : clock, async active-low reset
//   layer0, layer1   : per-layer links (scheduler side)
//   power_budget     : stack power limit, quasi-static
//   data_sel         : layer currently forwarded to data_out
//   data_out         : registered copy of that layer's data_in
//   all_done         : schedule finished without fault
//   fault            : a session timed out; cleared only by reset
//   concurrent       : latched decision was to test both layers together
module test_power_scheduler
  import test_power_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                   t_clk,
  input  logic                   rst_n,
  test_power_scheduler_if.master layer0,
  test_power_scheduler_if.master layer1,
  input  logic [SUM_W-1:0]       power_budget,
  output logic                   data_sel,
  output logic                   data_out,
  output logic                   all_done,
  output logic                   fault,
  output logic                   concurrent
);

  state_e    state;
  snapshot_t snap;
  snapshot_t live;
  logic      first;
  logic      second;
  logic      first_pick;
  logic      fits;
  logic      in_run;
  logic      expired;
  logic [1:0] sort_fin;
  logic [1:0] data_in;
  logic [1:0] done_ok;
  logic [1:0] done_seen;
  logic [1:0] start_q;
  logic [1:0] en_q;

  assign sort_fin = {layer1.sort_finish, layer0.sort_finish};
  assign data_in  = {layer1.data_in, layer0.data_in};
  // A done is only meaningful from a layer that is currently enabled.
  assign done_ok  = {layer1.test_done, layer0.test_done} & en_q;

  assign layer0.test_start = start_q[0];
  assign layer1.test_start = start_q[1];
  assign layer0.test_en    = en_q[0];
  assign layer1.test_en    = en_q[1];

  // NOTE: every signal written in always_comb gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    live        = '0;
    live.id0    = layer0.chip_id;
    live.id1    = layer1.chip_id;
    live.up0    = layer0.power_value_upper;
    live.up1    = layer1.power_value_upper;
    live.lo0    = layer0.power_value_lower;
    live.lo1    = layer1.power_value_lower;
    live.budget = power_budget;
  end

  assign first_pick = (snap.id1 < snap.id0);
  assign fits       = peak_power(snap.up0, snap.up1, snap.lo0, snap.lo1) <= snap.budget;
  assign second     = ~first;
  assign in_run     = state inside {RUN_BOTH, RUN_FIRST, RUN_SECOND};

  session_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .t_clk   (t_clk),
    .rst_n   (rst_n),
    .clear   (|start_q),
    .enable  (in_run),
    .expired (expired)
  );

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SORT;
      snap       <= '0;
      first      <= 1'b0;
      done_seen  <= '0;
      start_q    <= '0;
      en_q       <= '0;
      data_sel   <= 1'b0;
      all_done   <= 1'b0;
      fault      <= 1'b0;
      concurrent <= 1'b0;
    end else begin
      start_q <= '0;
      case (state)
        WAIT_SORT: begin
          // Sort results are guaranteed valid in this cycle, so capture
          // them here; DECIDE then works only from the snapshot.
          if (&sort_fin) begin
            snap  <= live;
            state <= DECIDE;
          end
        end

        DECIDE: begin
          first     <= first_pick;
          data_sel  <= first_pick;
          done_seen <= '0;
          if (fits) begin
            concurrent <= 1'b1;
            start_q    <= 2'b11;
            en_q       <= 2'b11;
            state      <= RUN_BOTH;
          end else begin
            start_q[first_pick] <= 1'b1;
            en_q[first_pick]    <= 1'b1;
            state               <= RUN_FIRST;
          end
        end

        RUN_BOTH: begin
          done_seen <= done_seen | done_ok;
          if (done_ok[0]) en_q[0] <= 1'b0;
          if (done_ok[1]) en_q[1] <= 1'b0;
          if (done_ok[first]) data_sel <= second;
          if (&(done_seen | done_ok)) begin
            all_done <= 1'b1;
            state    <= DONE;
          end else if (expired) begin
            fault <= 1'b1;
            en_q  <= '0;
            state <= FAULT;
          end
        end

        RUN_FIRST: begin
          // Hand-over happens in a single edge so the enables never overlap.
          if (done_ok[first]) begin
            en_q[first]     <= 1'b0;
            en_q[second]    <= 1'b1;
            start_q[second] <= 1'b1;
            data_sel        <= second;
            state           <= RUN_SECOND;
          end else if (expired) begin
            fault <= 1'b1;
            en_q  <= '0;
            state <= FAULT;
          end
        end

        RUN_SECOND: begin
          if (done_ok[second]) begin
            en_q[second] <= 1'b0;
            all_done     <= 1'b1;
            state        <= DONE;
          end else if (expired) begin
            fault <= 1'b1;
            en_q  <= '0;
            state <= FAULT;
          end
        end

        DONE: begin
          if (~|sort_fin) begin
            all_done   <= 1'b0;
            concurrent <= 1'b0;
            state      <= WAIT_SORT;
          end
        end

        FAULT: begin
          en_q <= '0;
        end

        default: state <= WAIT_SORT;
      endcase
    end
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) data_out <= 1'b0;
    else        data_out <= data_in[data_sel];
  end

endmodule

// File: tb/tb_test_power_scheduler.sv
// Directed bench for test_power_scheduler (TIMEOUT_CYC = 20).
// Outputs are sampled 1 ns after each rising edge and packed as
// {start_1, start_0, en_1, en_0, data_sel, all_done, fault, concurrent}.
module tb_test_power_scheduler;

  logic       t_clk;
  logic       rst_n;
  logic [4:0] power_budget;
  logic       data_sel, data_out, all_done, fault, concurrent;
  int         n_checks;
  int         n_passed;

  test_power_scheduler_if l0();
  test_power_scheduler_if l1();

  test_power_scheduler #(
    .TIMEOUT_CYC (20)
  ) dut (
    .t_clk        (t_clk),
    .rst_n        (rst_n),
    .layer0       (l0),
    .layer1       (l1),
    .power_budget (power_budget),
    .data_sel     (data_sel),
    .data_out     (data_out),
    .all_done     (all_done),
    .fault        (fault),
    .concurrent   (concurrent)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [7:0] outs();
    return {l1.test_start, l0.test_start, l1.test_en, l0.test_en,
            data_sel, all_done, fault, concurrent};
  endfunction

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic set_layers(input logic [3:0] id0, input logic [3:0] up0, input logic [3:0] lo0,
                            input logic [3:0] id1, input logic [3:0] up1, input logic [3:0] lo1,
                            input logic [4:0] budget);
    l0.chip_id = id0; l0.power_value_upper = up0; l0.power_value_lower = lo0;
    l1.chip_id = id1; l1.power_value_upper = up1; l1.power_value_lower = lo1;
    power_budget = budget;
  endtask

  task automatic set_sort(input logic v);
    l0.sort_finish = v;
    l1.sort_finish = v;
  endtask

  // Parallel schedule: ids 2/5, up 3/4, budget 10 -> both launch together.
  task automatic run_parallel(input string tag);
    set_layers(4'd2, 4'd3, 4'd1, 4'd5, 4'd4, 4'd2, 5'd10);
    set_sort(1'b1);
    tick();
    check({tag, "_decide"}, outs(), 8'b0000_0000);
    set_sort(1'b0);
    tick();
    check({tag, "_launch"}, outs(), 8'b1111_0001);
    tick();
    check({tag, "_running"}, outs(), 8'b0011_0001);
    l0.test_done = 1'b1;
    tick();
    l0.test_done = 1'b0;
    check({tag, "_done0"}, outs(), 8'b0010_1001);
    l1.test_done = 1'b1;
    tick();
    l1.test_done = 1'b0;
    check({tag, "_done1"}, outs(), 8'b0000_1101);
    tick();
    check({tag, "_idle"}, outs(), 8'b0000_1000);
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    rst_n = 1'b0;
    set_sort(1'b0);
    set_layers('0, '0, '0, '0, '0, '0, '0);
    l0.test_done = 1'b0; l1.test_done = 1'b0;
    l0.data_in   = 1'b0; l1.data_in   = 1'b0;

    tick();
    tick();
    check("reset_outs", outs(), 8'b0000_0000);
    check("reset_data_out", {7'd0, data_out}, 8'd0);
    rst_n = 1'b1;

    // Parallel run straight after reset release.
    run_parallel("par");

    // Sequential: ids 9/1, sum 13 > 10 -> layer 1 first. Inputs changed
    // during DECIDE must not alter the captured decision.
    set_layers(4'd9, 4'd7, 4'd2, 4'd1, 4'd6, 4'd3, 5'd10);
    set_sort(1'b1);
    tick();
    set_layers(4'd0, 4'd1, 4'd1, 4'd15, 4'd1, 4'd1, 5'd31);
    set_sort(1'b0);
    tick();
    check("seq_launch1", outs(), 8'b1010_1000);
    l1.data_in = 1'b1;
    l0.data_in = 1'b0;
    tick();
    check("seq_run1", outs(), 8'b0010_1000);
    check("seq_data_out1", {7'd0, data_out}, 8'd1);
    l1.test_done = 1'b1;
    tick();
    l1.test_done = 1'b0;
    check("seq_launch0", outs(), 8'b0101_0000);
    tick();
    check("seq_run0", outs(), 8'b0001_0000);
    check("seq_data_out0", {7'd0, data_out}, 8'd0);
    l0.test_done = 1'b1;
    tick();
    l0.test_done = 1'b0;
    check("seq_done", outs(), 8'b0000_0100);
    tick();
    check("seq_idle", outs(), 8'b0000_0000);
    l1.data_in = 1'b0;

    // Sequential with layer 0 first; a done from disabled layer 1 is ignored.
    set_layers(4'd1, 4'd8, 4'd2, 4'd3, 4'd8, 4'd2, 5'd10);
    set_sort(1'b1);
    tick();
    set_sort(1'b0);
    tick();
    check("stray_launch0", outs(), 8'b0101_0000);
    l1.test_done = 1'b1;
    tick();
    l1.test_done = 1'b0;
    check("stray_ignored", outs(), 8'b0001_0000);
    tick();
    check("stray_hold", outs(), 8'b0001_0000);
    l0.test_done = 1'b1;
    tick();
    l0.test_done = 1'b0;
    check("stray_launch1", outs(), 8'b1010_1000);
    l1.test_done = 1'b1;
    tick();
    l1.test_done = 1'b0;
    check("stray_done", outs(), 8'b0000_1100);
    tick();
    check("stray_idle", outs(), 8'b0000_1000);

    // Sum equal to budget -> parallel; both dones in one cycle finish at once.
    set_layers(4'd4, 4'd6, 4'd1, 4'd4, 4'd4, 4'd1, 5'd10);
    set_sort(1'b1);
    tick();
    set_sort(1'b0);
    tick();
    check("equal_launch", outs(), 8'b1111_0001);
    l0.test_done = 1'b1;
    l1.test_done = 1'b1;
    tick();
    l0.test_done = 1'b0;
    l1.test_done = 1'b0;
    check("equal_done", outs(), 8'b0000_1101);
    tick();
    check("equal_idle", outs(), 8'b0000_1000);

    // Reset asserted mid-parallel run clears everything immediately.
    set_layers(4'd2, 4'd3, 4'd1, 4'd5, 4'd4, 4'd2, 5'd10);
    set_sort(1'b1);
    tick();
    set_sort(1'b0);
    tick();
    tick();
    check("midrst_running", outs(), 8'b0011_0001);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", outs(), 8'b0000_0000);
    check("midrst_data_out", {7'd0, data_out}, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    run_parallel("after_rst");

    // Timeout: no done for 20 RUN cycles -> fault, enables drop, sticky.
    set_layers(4'd2, 4'd3, 4'd1, 4'd5, 4'd4, 4'd2, 5'd10);
    set_sort(1'b1);
    tick();
    set_sort(1'b0);
    tick();
    check("tmo_launch", outs(), 8'b1111_0001);
    for (int i = 0; i < 19; i++) tick();
    check("tmo_cycle19", outs(), 8'b0011_0001);
    tick();
    check("tmo_fault", outs(), 8'b0000_0011);
    set_sort(1'b1);
    l0.test_done = 1'b1;
    l1.test_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("tmo_sticky", outs(), 8'b0000_0011);
    set_sort(1'b0);
    l0.test_done = 1'b0;
    l1.test_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("tmo_reset", outs(), 8'b0000_0000);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
